voice_allocator: RTL and testbench
==================================

# voice_allocator

- Parametrised MIDI voice allocator for the synthesizer. It sits between the MIDI decoder and the per-voice oscillator/envelope banks.
- Maps note-on/note-off events onto VOICES voice slots. It tracks held, sustained and releasing voices, and emits one gate command per decision.
- Supports selectable voice-stealing modes and the sustain pedal.
- Drives keys_on, voice_free and an overflow-free active_keys count.

## Interface
- VOICES, 32, number of voice slots (2..64)
- V_WIDTH, 4, voice index width minus one; 2^(V_WIDTH+1) >= VOICES
- TS_W, 16, allocation timestamp width
- reg_clk  in  1  register-domain clock; the single clock of the block
- reset_reg_n  in  1  synchronous, active-low reset
- ev_valid  in  1  MIDI note event present
- ev_ready  out  1  block can accept an event
- ev_on  in  1  1 = note-on, 0 = note-off
- ev_note  in  7  MIDI note number
- ev_vel  in  7  velocity (note-on only)
- sustain  in  1  sustain pedal level (CC64 >= 64)
- steal_mode  in  2  0/3 = steal oldest held, 1 = steal lowest-note held, 2 = never steal
- env_done  in  VOICES  per-voice envelope finished (idle)
- keys_on  out  VOICES  voice gate held (key down, or key up while sustained)
- voice_free  out  VOICES  registered ~keys_on & env_done
- active_keys  out  V_WIDTH+2  popcount of keys_on (holds VOICES without wrap)
- gate_valid  out  1  one-cycle gate command strobe
- gate_voice  out  V_WIDTH+1  target voice
- gate_on  out  1  1 = start/retrigger, 0 = release
- gate_note, gate_vel  out  7 each  note/velocity for gate_on=1; note only for release
- gate_steal  out  1  gate_on=1 displaced a held voice

## Operation
- FSM states:
  - IDLE: ev_ready=1.
  - SCAN: one voice examined per cycle, index 0..VOICES-1.
  - DECIDE: commit the result, pulse the gate.
  - SWEEP: sustain release, one voice per cycle.
- IDLE transitions:
  - Pending sustain fall → SWEEP. This has priority over ev_valid.
  - Otherwise, ev_valid&ev_ready → latch the event, go to SCAN.
- SCAN tracks, in parallel:
  - a note match;
  - the lowest-index free voice;
  - the oldest releasing voice (keys_on=0, env_done=0);
  - the oldest held voice;
  - the lowest-note held voice (ties → lowest index).
- Note-on match rule: keys_on=1 and the voice note equals ev_note.
- Note-on priority:
  1. Match → retrigger the same voice.
  2. Else the lowest-index free voice.
  3. Else the oldest releasing voice.
  4. Else steal per steal_mode, with gate_steal=1.
  5. Else, in mode 2, drop the event: no gate, no state change.
- Note-on commit: keys_on=1, store note and vel, clear the sustained flag, set timestamp = ts_ctr, ts_ctr++ (once per accepted note-on, wraps).
- Age = ts_ctr - ts[v], modulo 2^TS_W. The largest age is the oldest; ties go to the lowest index.
- Note-off on a match, sustain=0: keys_on=0, gate_on=0.
- Note-off on a match, sustain=1: set the sustained flag. keys_on stays 1 and no gate is issued.
- Note-off with no match: no action.
- Sustain 1→0 edge (registered sustain compared with the input) sets sustain_pend.
  - SWEEP visits voices 0..VOICES-1.
  - For each sustained voice: clear keys_on and the flag, pulse gate_on=0.
  - Then clear sustain_pend and return to IDLE.
- An edge that occurs during SCAN/DECIDE/SWEEP stays latched until the next IDLE.

## Timing
- Reset (reset_reg_n=0 at a rising edge):
  - Clears keys_on, sustained flags, timestamps, ts_ctr, sustain_pend and gate_*.
  - voice_free=0, active_keys=0, ev_ready=0, FSM=IDLE.
  - Reset mid-scan or mid-sweep aborts with no gate.
- ev_ready is 1 from the first cycle after reset release.
- ev_ready is a registered output, 1 only in IDLE.
- Event accepted at edge T:
  - SCAN occupies T+1..T+VOICES.
  - DECIDE at T+VOICES+1.
  - gate_*, keys_on, active_keys and voice_free update, and ev_ready returns to 1, at T+VOICES+2.
  - Throughput is one event per VOICES+2 cycles.
- SWEEP costs VOICES cycles. Its gate pulses fall in the cycle after each visited voice.
- gate_valid is high exactly one cycle per command.
- gate_* fields are stable while gate_valid=1 and hold their last value otherwise.
- env_done is sampled during SCAN. voice_free lags env_done by one cycle.

## Test plan
- VOICES=4, steal_mode=0; note-on 60, 62, 64, 65 → gate_voice 0,1,2,3, gate_on=1, active_keys=4.
- Fifth note 67 with env_done=0 → voice 0 (oldest) with gate_steal=1, keys_on=4'b1111.
- steal_mode=2 → event dropped: no gate_valid, voice 0 keeps note 60.
- Note-on 60 (voice 0), then note-on 60 again → retrigger on voice 0, gate_steal=0, active_keys=1.
- sustain=1; note-off 60 → no gate, keys_on[0]=1.
- Then sustain=0 while a note-on 62 is pending on ev_valid → SWEEP issues gate_on=0 on voice 0 first, then 62 is allocated to voice 1. (env_done[0]=0, so voice 0 is releasing, not free.)
- Release voice 2 with env_done[2]=1, all other voices held; note-on → voice 2 with no steal, voice_free[2]=1 before the event.
- Reset asserted at cycle T+2 of a scan → no gate_valid. All outputs at their reset values the next cycle, and ev_ready=1 one cycle after release.
- Force ts_ctr to wrap past 2^TS_W; steal → the oldest by modular age is chosen.

Source files
------------

// File: rtl/voice_allocator.sv
// MIDI voice allocator: maps note events onto VOICES slots by scanning one voice per
// cycle, then commits a single gate command (retrigger, allocate, steal or release).
module voice_allocator #(
  parameter int VOICES  = 32,
  parameter int V_WIDTH = 4,
  parameter int TS_W    = 16
) (
  input  logic                reg_clk,
  input  logic                reset_reg_n,
  input  logic                ev_valid,
  output logic                ev_ready,
  input  logic                ev_on,
  input  logic [6:0]          ev_note,
  input  logic [6:0]          ev_vel,
  input  logic                sustain,
  input  logic [1:0]          steal_mode,
  input  logic [VOICES-1:0]   env_done,
  output logic [VOICES-1:0]   keys_on,
  output logic [VOICES-1:0]   voice_free,
  output logic [V_WIDTH+1:0]  active_keys,
  output logic                gate_valid,
  output logic [V_WIDTH:0]    gate_voice,
  output logic                gate_on,
  output logic [6:0]          gate_note,
  output logic [6:0]          gate_vel,
  output logic                gate_steal
);
  typedef enum logic [1:0] {IDLE, SCAN, DECIDE, SWEEP} state_t;
  localparam logic [V_WIDTH:0] LAST_IDX = (V_WIDTH+1)'(VOICES - 1);

  state_t state_reg, state_next;
  logic [V_WIDTH:0]    idx_reg;
  logic [VOICES-1:0]   keys_on_reg, keys_on_next, sus_reg, sus_next;
  logic [6:0]          note_mem [VOICES];
  logic [6:0]          vel_mem [VOICES];
  logic [TS_W-1:0]     ts_mem [VOICES];
  logic [TS_W-1:0]     ts_ctr_reg;
  logic                sus_q_reg, sustain_pend_reg, ev_ready_reg;
  logic                ev_on_reg;
  logic [6:0]          ev_note_reg, ev_vel_reg;
  logic                match_found_reg, free_found_reg, rel_found_reg, held_found_reg;
  logic [V_WIDTH:0]    match_idx_reg, free_idx_reg, rel_idx_reg, old_idx_reg, low_idx_reg;
  logic [TS_W-1:0]     rel_age_reg, old_age_reg;
  logic [6:0]          low_note_reg;
  logic [VOICES-1:0]   voice_free_reg;
  logic [V_WIDTH+1:0]  active_keys_reg, key_count;
  logic                gate_valid_reg, gate_on_reg, gate_steal_reg;
  logic [V_WIDTH:0]    gate_voice_reg;
  logic [6:0]          gate_note_reg, gate_vel_reg;

  logic                sweep_req, accept, last_idx;
  logic                cur_key, cur_env;
  logic [6:0]          cur_note;
  logic [TS_W-1:0]     cur_age;
  logic                alloc_ok, alloc_steal;
  logic [V_WIDTH:0]    alloc_idx;
  logic                do_on, do_off, do_hold, do_sweep;

  // A live pedal fall counts immediately so it wins over an event offered the same cycle.
  assign sweep_req = sustain_pend_reg | (sus_q_reg & ~sustain);
  assign accept    = (state_reg == IDLE) & ~sweep_req & ev_valid & ev_ready_reg;
  assign last_idx  = (idx_reg == LAST_IDX);

  assign cur_key  = keys_on_reg[idx_reg];
  assign cur_env  = env_done[idx_reg];
  assign cur_note = note_mem[idx_reg];
  assign cur_age  = ts_ctr_reg - ts_mem[idx_reg];

  always_comb begin
    alloc_ok    = 1'b1;
    alloc_steal = 1'b0;
    alloc_idx   = match_idx_reg;
    if (match_found_reg) begin
      alloc_idx = match_idx_reg;
    end else if (free_found_reg) begin
      alloc_idx = free_idx_reg;
    end else if (rel_found_reg) begin
      alloc_idx = rel_idx_reg;
    end else if (held_found_reg && steal_mode != 2'd2) begin
      alloc_steal = 1'b1;
      alloc_idx   = (steal_mode == 2'd1) ? low_idx_reg : old_idx_reg;
    end else begin
      alloc_ok = 1'b0;
    end
  end

  assign do_on    = (state_reg == DECIDE) & ev_on_reg & alloc_ok;
  assign do_off   = (state_reg == DECIDE) & ~ev_on_reg & match_found_reg & ~sustain;
  assign do_hold  = (state_reg == DECIDE) & ~ev_on_reg & match_found_reg & sustain;
  assign do_sweep = (state_reg == SWEEP) & sus_reg[idx_reg];

  always_comb begin
    keys_on_next = keys_on_reg;
    sus_next     = sus_reg;
    if (do_on) begin
      keys_on_next[alloc_idx] = 1'b1;
      sus_next[alloc_idx]     = 1'b0;
    end
    if (do_off) begin
      keys_on_next[match_idx_reg] = 1'b0;
      sus_next[match_idx_reg]     = 1'b0;
    end
    if (do_hold) begin
      sus_next[match_idx_reg] = 1'b1;
    end
    if (do_sweep) begin
      keys_on_next[idx_reg] = 1'b0;
      sus_next[idx_reg]     = 1'b0;
    end
  end

  always_comb begin
    key_count = '0;
    for (int i = 0; i < VOICES; i++) begin
      key_count = key_count + (V_WIDTH+2)'(keys_on_next[i]);
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (sweep_req) state_next = SWEEP;
               else if (accept) state_next = SCAN;
      SCAN:    if (last_idx) state_next = DECIDE;
      DECIDE:  state_next = IDLE;
      SWEEP:   if (last_idx) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge reg_clk) begin
    if (!reset_reg_n) state_reg <= IDLE;
    else state_reg <= state_next;
  end

  always_ff @(posedge reg_clk) begin
    if (!reset_reg_n) begin
      idx_reg          <= '0;
      keys_on_reg      <= '0;
      sus_reg          <= '0;
      ts_ctr_reg       <= '0;
      for (int i = 0; i < VOICES; i++) begin
        note_mem[i] <= '0;
        vel_mem[i]  <= '0;
        ts_mem[i]   <= '0;
      end
      sus_q_reg        <= 1'b0;
      sustain_pend_reg <= 1'b0;
      ev_ready_reg     <= 1'b0;
      ev_on_reg        <= 1'b0;
      ev_note_reg      <= '0;
      ev_vel_reg       <= '0;
      match_found_reg  <= 1'b0;
      free_found_reg   <= 1'b0;
      rel_found_reg    <= 1'b0;
      held_found_reg   <= 1'b0;
      match_idx_reg    <= '0;
      free_idx_reg     <= '0;
      rel_idx_reg      <= '0;
      old_idx_reg      <= '0;
      low_idx_reg      <= '0;
      rel_age_reg      <= '0;
      old_age_reg      <= '0;
      low_note_reg     <= '0;
      voice_free_reg   <= '0;
      active_keys_reg  <= '0;
      gate_valid_reg   <= 1'b0;
      gate_voice_reg   <= '0;
      gate_on_reg      <= 1'b0;
      gate_note_reg    <= '0;
      gate_vel_reg     <= '0;
      gate_steal_reg   <= 1'b0;
    end else begin
      gate_valid_reg  <= 1'b0;
      sus_q_reg       <= sustain;
      keys_on_reg     <= keys_on_next;
      sus_reg         <= sus_next;
      voice_free_reg  <= ~keys_on_next & env_done;
      active_keys_reg <= key_count;
      ev_ready_reg    <= (state_next == IDLE);
      // A new fall during the final sweep step must survive the clear.
      if (sus_q_reg && !sustain) sustain_pend_reg <= 1'b1;
      else if (state_reg == SWEEP && last_idx) sustain_pend_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          idx_reg <= '0;
          if (accept) begin
            ev_on_reg       <= ev_on;
            ev_note_reg     <= ev_note;
            ev_vel_reg      <= ev_vel;
            match_found_reg <= 1'b0;
            free_found_reg  <= 1'b0;
            rel_found_reg   <= 1'b0;
            held_found_reg  <= 1'b0;
          end
        end
        SCAN: begin
          if (cur_key && cur_note == ev_note_reg && !match_found_reg) begin
            match_found_reg <= 1'b1;
            match_idx_reg   <= idx_reg;
          end
          if (!cur_key && cur_env && !free_found_reg) begin
            free_found_reg <= 1'b1;
            free_idx_reg   <= idx_reg;
          end
          if (!cur_key && !cur_env && (!rel_found_reg || cur_age > rel_age_reg)) begin
            rel_found_reg <= 1'b1;
            rel_idx_reg   <= idx_reg;
            rel_age_reg   <= cur_age;
          end
          if (cur_key) begin
            held_found_reg <= 1'b1;
            if (!held_found_reg || cur_age > old_age_reg) begin
              old_idx_reg <= idx_reg;
              old_age_reg <= cur_age;
            end
            if (!held_found_reg || cur_note < low_note_reg) begin
              low_idx_reg  <= idx_reg;
              low_note_reg <= cur_note;
            end
          end
          idx_reg <= last_idx ? '0 : idx_reg + 1'b1;
        end
        DECIDE: begin
          if (do_on) begin
            note_mem[alloc_idx] <= ev_note_reg;
            vel_mem[alloc_idx]  <= ev_vel_reg;
            ts_mem[alloc_idx]   <= ts_ctr_reg;
            ts_ctr_reg          <= ts_ctr_reg + 1'b1;
            gate_valid_reg      <= 1'b1;
            gate_voice_reg      <= alloc_idx;
            gate_on_reg         <= 1'b1;
            gate_note_reg       <= ev_note_reg;
            gate_vel_reg        <= ev_vel_reg;
            gate_steal_reg      <= alloc_steal;
          end
          if (do_off) begin
            gate_valid_reg <= 1'b1;
            gate_voice_reg <= match_idx_reg;
            gate_on_reg    <= 1'b0;
            gate_note_reg  <= note_mem[match_idx_reg];
            gate_steal_reg <= 1'b0;
          end
        end
        SWEEP: begin
          if (do_sweep) begin
            gate_valid_reg <= 1'b1;
            gate_voice_reg <= idx_reg;
            gate_on_reg    <= 1'b0;
            gate_note_reg  <= note_mem[idx_reg];
            gate_steal_reg <= 1'b0;
          end
          idx_reg <= last_idx ? '0 : idx_reg + 1'b1;
        end
        default: idx_reg <= '0;
      endcase
    end
  end

  assign ev_ready    = ev_ready_reg;
  assign keys_on     = keys_on_reg;
  assign voice_free  = voice_free_reg;
  assign active_keys = active_keys_reg;
  assign gate_valid  = gate_valid_reg;
  assign gate_voice  = gate_voice_reg;
  assign gate_on     = gate_on_reg;
  assign gate_note   = gate_note_reg;
  assign gate_vel    = gate_vel_reg;
  assign gate_steal  = gate_steal_reg;
endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed scenarios plus random events, checked against a
// rule-level allocation model with modular-age ordering.
module tb_voice_allocator;
  localparam int V  = 4;
  localparam int VW = 1;
  localparam int TW = 4;

  logic          reg_clk = 1'b0;
  logic          reset_reg_n = 1'b0;
  logic          ev_valid = 1'b0;
  logic          ev_on = 1'b0;
  logic [6:0]    ev_note = '0;
  logic [6:0]    ev_vel = '0;
  logic          sustain = 1'b0;
  logic [1:0]    steal_mode = '0;
  logic [V-1:0]  env_done = '1;
  logic          ev_ready;
  logic [V-1:0]  keys_on, voice_free;
  logic [VW+1:0] active_keys;
  logic          gate_valid, gate_on, gate_steal;
  logic [VW:0]   gate_voice;
  logic [6:0]    gate_note, gate_vel;

  always #5 reg_clk = ~reg_clk;

  voice_allocator #(.VOICES(V), .V_WIDTH(VW), .TS_W(TW)) dut (
    .reg_clk(reg_clk), .reset_reg_n(reset_reg_n),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_on(ev_on),
    .ev_note(ev_note), .ev_vel(ev_vel), .sustain(sustain),
    .steal_mode(steal_mode), .env_done(env_done),
    .keys_on(keys_on), .voice_free(voice_free), .active_keys(active_keys),
    .gate_valid(gate_valid), .gate_voice(gate_voice), .gate_on(gate_on),
    .gate_note(gate_note), .gate_vel(gate_vel), .gate_steal(gate_steal)
  );

  typedef struct {int voice; bit on; int note; int vel; bit steal;} gate_t;
  gate_t gq[$];
  gate_t eq[$];
  gate_t last_gate;
  int total = 0;
  int bad = 0;

  int m_key[V], m_sus[V], m_note[V], m_vel[V], m_ts[V];
  int m_ctr;

  always @(negedge reg_clk) begin
    gate_t g;
    if (gate_valid === 1'b1) begin
      g.voice = int'(gate_voice);
      g.on    = gate_on;
      g.note  = int'(gate_note);
      g.vel   = int'(gate_vel);
      g.steal = gate_steal;
      gq.push_back(g);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge reg_clk);
    #1;
  endtask

  function automatic int age(input int v);
    return (m_ctr - m_ts[v]) & ((1 << TW) - 1);
  endfunction

  function automatic logic [V-1:0] model_keys();
    logic [V-1:0] k;
    for (int v = 0; v < V; v++) k[v] = (m_key[v] != 0);
    return k;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < V; v++) begin
      m_key[v] = 0; m_sus[v] = 0; m_note[v] = 0; m_vel[v] = 0; m_ts[v] = 0;
    end
    m_ctr = 0;
    eq.delete();
    gq.delete();
  endtask

  task automatic model_event(input bit on, input int note, input int vel);
    int tgt = -1;
    bit st = 1'b0;
    for (int v = 0; v < V; v++)
      if (tgt < 0 && m_key[v] != 0 && m_note[v] == note) tgt = v;
    if (!on) begin
      if (tgt >= 0) begin
        if (sustain) m_sus[tgt] = 1;
        else begin
          m_key[tgt] = 0; m_sus[tgt] = 0;
          eq.push_back('{voice: tgt, on: 1'b0, note: m_note[tgt], vel: 0, steal: 1'b0});
        end
      end
      return;
    end
    for (int v = 0; v < V; v++)
      if (tgt < 0 && m_key[v] == 0 && env_done[v]) tgt = v;
    if (tgt < 0) begin
      int best = -1;
      for (int v = 0; v < V; v++)
        if (m_key[v] == 0 && !env_done[v] && (best < 0 || age(v) > age(best))) best = v;
      tgt = best;
    end
    if (tgt < 0 && steal_mode != 2'd2) begin
      int best = -1;
      for (int v = 0; v < V; v++) begin
        if (m_key[v] == 0) continue;
        if (best < 0) best = v;
        else if (steal_mode == 2'd1 && m_note[v] < m_note[best]) best = v;
        else if (steal_mode != 2'd1 && age(v) > age(best)) best = v;
      end
      tgt = best;
      st = (best >= 0);
    end
    if (tgt < 0) return;
    m_key[tgt] = 1; m_sus[tgt] = 0; m_note[tgt] = note; m_vel[tgt] = vel;
    m_ts[tgt] = m_ctr;
    m_ctr = (m_ctr + 1) & ((1 << TW) - 1);
    eq.push_back('{voice: tgt, on: 1'b1, note: note, vel: vel, steal: st});
  endtask

  task automatic model_sweep();
    for (int v = 0; v < V; v++)
      if (m_sus[v] != 0) begin
        m_key[v] = 0; m_sus[v] = 0;
        eq.push_back('{voice: v, on: 1'b0, note: m_note[v], vel: 0, steal: 1'b0});
      end
  endtask

  task automatic cmp_gates(input string tag);
    gate_t g, e;
    check_eq({tag, "_gate_count"}, gq.size(), eq.size());
    while (gq.size() > 0 && eq.size() > 0) begin
      g = gq.pop_front();
      e = eq.pop_front();
      last_gate = g;
      check_eq({tag, "_voice"}, g.voice, e.voice);
      check_eq({tag, "_on"}, g.on, e.on);
      check_eq({tag, "_note"}, g.note, e.note);
      if (e.on) begin
        check_eq({tag, "_vel"}, g.vel, e.vel);
        check_eq({tag, "_steal"}, g.steal, e.steal);
      end
    end
    gq.delete();
    eq.delete();
  endtask

  task automatic check_state(input string tag);
    logic [V-1:0] k;
    int cnt = 0;
    k = model_keys();
    for (int v = 0; v < V; v++) cnt += m_key[v];
    check_eq({tag, "_keys_on"}, keys_on, k);
    check_eq({tag, "_active"}, active_keys, cnt);
    check_eq({tag, "_voice_free"}, voice_free, ~k & env_done);
  endtask

  task automatic await_result(input bit on, input int note, input int vel);
    repeat (V) step();
    check_eq("early_gate", gq.size(), 0);
    check_eq("busy_ready", ev_ready, 1'b0);
    step();
    check_eq("ready_back", ev_ready, 1'b1);
    model_event(on, note, vel);
    $display("event on=%0d note=%0d vel=%0d mode=%0d env=%b -> gates=%0d keys_on=%b",
             on, note, vel, steal_mode, env_done, gq.size(), keys_on);
    cmp_gates("ev");
    check_state("ev");
  endtask

  task automatic send(input bit on, input int note, input int vel);
    int n = 0;
    while (ev_ready !== 1'b1 && n < 100) begin step(); n++; end
    if (ev_ready !== 1'b1) check_eq("ready_timeout", ev_ready, 1'b1);
    ev_on = on; ev_note = 7'(note); ev_vel = 7'(vel); ev_valid = 1'b1;
    step();
    ev_valid = 1'b0;
    await_result(on, note, vel);
  endtask

  task automatic release_sustain(input bit with_ev, input bit on, input int note, input int vel);
    sustain = 1'b0;
    if (with_ev) begin
      ev_on = on; ev_note = 7'(note); ev_vel = 7'(vel); ev_valid = 1'b1;
    end
    step();
    check_eq("sweep_busy", ev_ready, 1'b0);
    repeat (V) step();
    model_sweep();
    $display("sweep with_ev=%0d -> gates=%0d keys_on=%b", with_ev, gq.size(), keys_on);
    cmp_gates("sweep");
    check_eq("sweep_ready", ev_ready, 1'b1);
    if (with_ev) begin
      step();
      ev_valid = 1'b0;
      await_result(on, note, vel);
    end else begin
      check_state("sweep");
    end
  endtask

  task automatic do_reset();
    reset_reg_n = 1'b0;
    step();
    step();
    reset_reg_n = 1'b1;
    step();
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    step();
    step();
    check_eq("rst_ready", ev_ready, 1'b0);
    check_eq("rst_keys", keys_on, 0);
    check_eq("rst_free", voice_free, 0);
    check_eq("rst_active", active_keys, 0);
    check_eq("rst_gate_valid", gate_valid, 1'b0);
    reset_reg_n = 1'b1;
    step();
    check_eq("rst_ready_after", ev_ready, 1'b1);
    model_reset();

    // Fill all voices, drop in mode 2, then steal the oldest.
    env_done = '1;
    send(1, 60, 10); send(1, 62, 20); send(1, 64, 30); send(1, 65, 40);
    check_eq("fill_keys", keys_on, 4'b1111);
    check_eq("fill_active", active_keys, 4);
    env_done = '0;
    steal_mode = 2'd2;
    step();
    send(1, 67, 50);
    steal_mode = 2'd0;
    send(1, 67, 51);
    check_eq("steal_voice", last_gate.voice, 0);
    check_eq("steal_flag", last_gate.steal, 1);
    check_eq("steal_keys", keys_on, 4'b1111);
    send(0, 67, 0);
    check_eq("rel_after_steal_voice", last_gate.voice, 0);

    // Retrigger, sustain hold, pedal release with a pending note-on.
    do_reset();
    env_done = '1;
    step();
    send(1, 60, 70);
    send(1, 60, 71);
    check_eq("retrig_voice", last_gate.voice, 0);
    check_eq("retrig_steal", last_gate.steal, 0);
    check_eq("retrig_active", active_keys, 1);
    sustain = 1'b1;
    step();
    send(0, 60, 0);
    check_eq("sus_hold_key0", keys_on[0], 1'b1);
    env_done = 4'b1110;
    step();
    release_sustain(1, 1, 62, 90);
    check_eq("after_sweep_voice", last_gate.voice, 1);

    // Released voice with finished envelope is reused without stealing.
    do_reset();
    env_done = '1;
    step();
    send(1, 60, 1); send(1, 62, 2); send(1, 64, 3); send(1, 65, 4);
    env_done = 4'b0100;
    step();
    send(0, 64, 0);
    step();
    check_eq("free2_vector", voice_free, 4'b0100);
    send(1, 70, 5);
    check_eq("free2_voice", last_gate.voice, 2);
    check_eq("free2_steal", last_gate.steal, 0);

    // Reset in the middle of a scan aborts without a gate.
    do_reset();
    env_done = '1;
    step();
    send(1, 61, 9);
    ev_on = 1'b1; ev_note = 7'd63; ev_vel = 7'd9; ev_valid = 1'b1;
    step();
    ev_valid = 1'b0;
    step();
    reset_reg_n = 1'b0;
    step();
    check_eq("abort_gate_valid", gate_valid, 1'b0);
    check_eq("abort_keys", keys_on, 0);
    check_eq("abort_free", voice_free, 0);
    check_eq("abort_active", active_keys, 0);
    check_eq("abort_ready", ev_ready, 1'b0);
    check_eq("abort_gate_fields", {gate_voice, gate_on, gate_note, gate_vel, gate_steal}, 0);
    reset_reg_n = 1'b1;
    step();
    check_eq("abort_ready_after", ev_ready, 1'b1);
    repeat (V + 3) step();
    check_eq("abort_no_gate", gq.size(), 0);
    model_reset();

    // Timestamp wrap: keep stealing past 2^TW allocations.
    env_done = '0;
    steal_mode = 2'd0;
    step();
    for (int i = 0; i < 22; i++) send(1, 30 + i, 1 + i);
    steal_mode = 2'd1;
    step();
    for (int i = 0; i < 4; i++) send(1, 90 - i, 50);

    // Random mix of note-on/off, modes, envelopes and pedal moves.
    do_reset();
    for (int it = 0; it < 150; it++) begin
      int r = $urandom_range(0, 9);
      env_done = V'($urandom);
      steal_mode = 2'($urandom_range(0, 3));
      step();
      if (r == 0) begin
        if (!sustain) begin
          sustain = 1'b1;
          step();
        end else begin
          release_sustain(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          60 + $urandom_range(0, 7), $urandom_range(1, 127));
        end
      end else begin
        send(($urandom_range(0, 2) != 0), 60 + $urandom_range(0, 7), $urandom_range(1, 127));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
